// File: rtl/id_ext_pipe.sv
// Pipelined ID-stage immediate extender: one output register plus a 1-entry skid
// buffer behind a valid/ready handshake, with a LUI latch feeding the CAT mode.
module id_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_res,
    output logic [IN_W-1:0]  lui_hi
);

    localparam logic [2:0] MODE_ZERO = 3'd0;
    localparam logic [2:0] MODE_SHL  = 3'd1;
    localparam logic [2:0] MODE_SIGN = 3'd2;
    localparam logic [2:0] MODE_LUI  = 3'd3;
    localparam logic [2:0] MODE_ONE  = 3'd4;
    localparam logic [2:0] MODE_SSHL = 3'd5;
    localparam logic [2:0] MODE_CAT  = 3'd6;

    // Bits above the immediate; empty when OUT_W == IN_W.
    localparam logic [OUT_W-1:0] HI_MASK = {OUT_W{1'b1}} << IN_W;

    function automatic logic [OUT_W-1:0] ext_imm(
        input logic [IN_W-1:0] e,
        input logic [2:0]      mode,
        input logic [IN_W-1:0] hi
    );
        logic        [OUT_W-1:0]  zx;
        logic signed [OUT_W-1:0]  sx;
        logic        [2*IN_W-1:0] cat;
        logic        [OUT_W-1:0]  res;
        zx  = OUT_W'(e);
        sx  = signed'(e[IN_W-1] ? (zx | HI_MASK) : zx);
        cat = {hi, e};
        res = '0;
        case (mode)
            MODE_ZERO: res = zx;
            MODE_SHL:  res = zx << SHIFT;
            MODE_SIGN: res = sx;
            MODE_LUI:  res = zx << (OUT_W - IN_W);
            MODE_ONE:  res = zx | HI_MASK;
            MODE_SSHL: res = sx <<< SHIFT;
            MODE_CAT:  res = cat[OUT_W-1:0];
            default:   res = '0;
        endcase
        return res;
    endfunction

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_res;
    logic             r_skid_valid;
    logic [OUT_W-1:0] r_skid_res;
    logic [IN_W-1:0]  r_lui_hi;

    logic             w_accept;
    logic             w_fire;
    logic [OUT_W-1:0] w_res;

    assign in_ready  = reset & ~r_skid_valid & ~flush;
    assign w_accept  = in_valid & in_ready;
    assign w_fire    = r_out_valid & out_ready;
    // CAT reads the registered latch, so a same-cycle LUI is not yet visible.
    assign w_res     = ext_imm(in_imm, in_mode, r_lui_hi);

    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;
    assign lui_hi    = r_lui_hi;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_res    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_res   <= '0;
            r_lui_hi     <= '0;
        end else begin
            if (w_accept && in_mode == MODE_LUI)
                r_lui_hi <= in_imm;
            if (flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (!r_out_valid || w_fire) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_res    <= r_skid_res;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_out_valid <= 1'b1;
                    r_out_res   <= w_res;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_valid <= 1'b1;
                r_skid_res   <= w_res;
            end
        end
    end

endmodule

// File: tb/tb_id_ext_pipe.sv
// Directed self-checking bench for id_ext_pipe: default parameters plus a
// narrow 12->20 bit instance.
module tb_id_ext_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [15:0] in_imm, lui_hi;
    logic [2:0]  in_mode;
    logic [31:0] out_res;

    logic        reset2, flush2, in_valid2, out_ready2;
    logic        in_ready2, out_valid2;
    logic [11:0] in_imm2, lui_hi2;
    logic [2:0]  in_mode2;
    logic [19:0] out_res2;

    int n_tests = 0;
    int n_fail  = 0;

    id_ext_pipe u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .lui_hi(lui_hi)
    );

    id_ext_pipe #(.IN_W(12), .OUT_W(20), .SHIFT(1)) u_dut2 (
        .clk(clk), .reset(reset2), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_imm(in_imm2), .in_mode(in_mode2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_res(out_res2), .lui_hi(lui_hi2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] m, input logic [15:0] imm);
        in_valid = v;
        in_mode  = m;
        in_imm   = imm;
    endtask

    logic [2:0]  modes [8];
    logic [31:0] exps  [8];

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 3'd0, 16'h0);
        reset2 = 1'b0; flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1;
        in_imm2 = 12'h0; in_mode2 = 3'd0;

        // Reset state
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_res",   out_res,        32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_lui_hi",    32'(lui_hi),    32'd0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready",  32'(in_ready),  32'd1);

        // All modes on 0x8001; CAT first so the latch is still zero
        modes = '{3'd6, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
        exps  = '{32'h00008001, 32'h00008001, 32'h00020004, 32'hFFFF8001,
                  32'h80010000, 32'hFFFF8001, 32'hFFFE0004, 32'h00000000};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, modes[i], 16'h8001);
            step();
            chk($sformatf("mode%0d_valid", modes[i]), 32'(out_valid), 32'd1);
            chk($sformatf("mode%0d_res", modes[i]),   out_res,        exps[i]);
        end
        chk("lui_hi_after_modes", 32'(lui_hi), 32'h8001);

        // LUI then CAT back-to-back
        drive(1'b1, 3'd3, 16'h1234);
        step();
        chk("lui_res",  out_res,        32'h12340000);
        chk("lui_hi",   32'(lui_hi),    32'h1234);
        drive(1'b1, 3'd6, 16'h5678);
        step();
        chk("cat_res",  out_res,        32'h12345678);
        drive(1'b0, 3'd0, 16'h0);
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_hold",  out_res,        32'h12345678);

        // Stall stream 1..4
        drive(1'b1, 3'd0, 16'd1);
        step();
        chk("s1_res", out_res, 32'd1);
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'd2);
        step();
        chk("s2_in_ready", 32'(in_ready), 32'd0);
        chk("s2_hold",     out_res,       32'd1);
        drive(1'b1, 3'd0, 16'd3);
        step();
        chk("s3_hold",     out_res,        32'd1);
        chk("s3_valid",    32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        chk("s4_res",      out_res,       32'd2);
        chk("s4_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("s5_res",      out_res,       32'd3);
        drive(1'b1, 3'd0, 16'd4);
        step();
        chk("s6_res",      out_res,       32'd4);
        drive(1'b0, 3'd0, 16'h0);
        step();
        chk("s7_valid",    32'(out_valid), 32'd0);

        // Flush with output and skid full; LUI offered during flush
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h00AA);
        step();
        drive(1'b1, 3'd0, 16'h00BB);
        step();
        chk("fl_full_in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        drive(1'b1, 3'd3, 16'h7777);
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 3'd0, 16'h0);
        #1;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready2", 32'(in_ready),  32'd1);
        chk("fl_lui_hi",    32'(lui_hi),    32'h1234);
        chk("fl_res_hold",  out_res,        32'h000000AA);
        out_ready = 1'b1;
        step();
        chk("fl_skid_empty", 32'(out_valid), 32'd0);

        // Reset with output and skid full
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h00CC);
        step();
        drive(1'b1, 3'd0, 16'h00DD);
        step();
        reset = 1'b0;
        step();
        chk("rr_out_valid", 32'(out_valid), 32'd0);
        chk("rr_out_res",   out_res,        32'd0);
        chk("rr_in_ready",  32'(in_ready),  32'd0);
        chk("rr_lui_hi",    32'(lui_hi),    32'd0);
        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, 16'h0);
        step();
        chk("rr_skid_gone",  32'(out_valid), 32'd0);
        chk("rr_in_ready2",  32'(in_ready),  32'd1);
        drive(1'b1, 3'd2, 16'h8001);
        step();
        chk("rr_first_valid", 32'(out_valid), 32'd1);
        chk("rr_first_res",   out_res,        32'hFFFF8001);
        drive(1'b0, 3'd0, 16'h0);

        // Narrow parameter set 12 -> 20, SHIFT 1
        reset2 = 1'b1;
        in_valid2 = 1'b1; in_mode2 = 3'd2; in_imm2 = 12'h800;
        step();
        chk("p2_sign", 32'(out_res2), 32'h000FF800);
        in_mode2 = 3'd3; in_imm2 = 12'hABC;
        step();
        chk("p2_lui", 32'(out_res2), 32'h000ABC00);
        chk("p2_lui_hi", 32'(lui_hi2), 32'h00000ABC);
        in_mode2 = 3'd5; in_imm2 = 12'hFFF;
        step();
        chk("p2_sshl", 32'(out_res2), 32'h000FFFFE);
        in_mode2 = 3'd6; in_imm2 = 12'h123;
        step();
        chk("p2_cat", 32'(out_res2), 32'h000BC123);
        in_valid2 = 1'b0;
        step();
        chk("p2_idle", 32'(out_valid2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
